// File: rtl/sim_eoc_mailbox_if.sv
// Core data-port bundle between the zero-riscy LSU and the EOC/console mailbox.
interface sim_eoc_mailbox_if;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        sel_o;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  sel_o, data_gnt_o, data_rvalid_o, data_rdata_o
  );

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output sel_o, data_gnt_o, data_rvalid_o, data_rdata_o
  );
endinterface

// File: rtl/sim_eoc_mailbox.sv
// Exit-code / putchar mailbox with console FIFO and end-of-simulation sequencer.
// Optional console/finish system tasks: define SIM_EOC_MAILBOX_DISPLAY_EN.
module sim_eoc_mailbox #(
  parameter logic [31:0] ADDR_EXIT    = 32'h8000_0000,
  parameter logic [31:0] ADDR_PUTC    = 32'h8000_0004,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned DRAIN_CYCLES = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  sim_eoc_mailbox_if.slave         data_if,
  input  logic                     core_sleeping_i,
  output logic                     char_valid_o,
  output logic [7:0]               char_o,
  input  logic                     char_ready_i,
  output logic                     exit_valid_o,
  output logic [31:0]              exit_code_o,
  output logic                     eoc_o,
  output logic                     finish_o
);

  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0]  FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {RUN, WAIT_SLEEP, DRAIN, DONE} state_e;

  state_e         state_q, state_d;
  logic [DCW-1:0] cnt_q, cnt_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic hit_exit, hit_putc, putc_st, exit_st;
  logic fifo_full, fifo_empty, push, pop, unused_be;

  assign hit_exit = data_if.data_req_i & (data_if.data_addr_i == ADDR_EXIT);
  assign hit_putc = data_if.data_req_i & (data_if.data_addr_i == ADDR_PUTC);
  assign putc_st  = hit_putc & data_if.data_we_i;
  assign exit_st  = hit_exit & data_if.data_we_i;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);

  assign data_if.sel_o      = hit_exit | hit_putc;
  assign data_if.data_gnt_o = data_if.sel_o & ~(putc_st & fifo_full);

  assign push = data_if.data_gnt_o & putc_st & data_if.data_be_i[0];
  assign pop  = char_valid_o & char_ready_i;

  assign char_valid_o = ~fifo_empty;
  assign char_o       = mem_q[rd_ptr_q];
  assign unused_be    = ^data_if.data_be_i[3:1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= data_if.data_wdata_i[7:0];
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Load data is sampled in the grant cycle, so occupancy reflects pre-push/pop state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_if.data_rvalid_o <= 1'b0;
      data_if.data_rdata_o  <= '0;
    end else begin
      data_if.data_rvalid_o <= data_if.data_gnt_o;
      if (data_if.data_gnt_o && !data_if.data_we_i) begin
        if (hit_exit) data_if.data_rdata_o <= exit_valid_o ? exit_code_o : '1;
        else          data_if.data_rdata_o <= 32'(count_q);
      end else begin
        data_if.data_rdata_o <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exit_valid_o <= 1'b0;
      exit_code_o  <= '0;
    end else if (data_if.data_gnt_o && exit_st && !exit_valid_o) begin
      exit_valid_o <= 1'b1;
      exit_code_o  <= data_if.data_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN:        if (exit_valid_o) state_d = WAIT_SLEEP;
      WAIT_SLEEP: if (core_sleeping_i && fifo_empty) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_LOAD;
                  end
      DRAIN:      if (cnt_q == '0) state_d = DONE;
                  else             cnt_d   = cnt_q - DCW'(1);
      DONE:       state_d = DONE;
      default:    state_d = RUN;
    endcase
  end

  assign eoc_o    = (state_q == DRAIN) || (state_q == DONE);
  assign finish_o = (state_q == DONE);

`ifdef SIM_EOC_MAILBOX_DISPLAY_EN
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (pop) $write("%c", char_o);
      if (state_q == WAIT_SLEEP && state_d == DRAIN) $display("errors=%08x", exit_code_o);
      if (state_q == DRAIN && state_d == DONE) $finish;
    end
  end
`else
  // Console output and simulation finish are left to the enclosing harness.
`endif

endmodule

// File: tb/tb_sim_eoc_mailbox.sv
// Scoreboard bench for sim_eoc_mailbox: directed bus/FIFO/EOC vectors with queued expectations.
module tb_sim_eoc_mailbox;
  localparam logic [31:0] A_EXIT = 32'h8000_0000;
  localparam logic [31:0] A_PUTC = 32'h8000_0004;
  localparam logic [31:0] A_MISS = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_sleeping = 1'b0;
  logic        char_ready = 1'b0;
  logic        char_valid;
  logic [7:0]  char_o;
  logic        exit_valid;
  logic [31:0] exit_code;
  logic        eoc, finish;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct { int cyc; logic [31:0] data; } resp_t;
  resp_t      rq[$];
  logic [7:0] cq[$];

  sim_eoc_mailbox_if bus ();

  sim_eoc_mailbox #(
    .ADDR_EXIT(A_EXIT), .ADDR_PUTC(A_PUTC), .FIFO_DEPTH(16), .DRAIN_CYCLES(10)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_if(bus), .core_sleeping_i(core_sleeping),
    .char_valid_o(char_valid), .char_o(char_o), .char_ready_i(char_ready),
    .exit_valid_o(exit_valid), .exit_code_o(exit_code), .eoc_o(eoc), .finish_o(finish)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: responses and consumed characters are checked against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.data_rvalid_o) begin
        if (rq.size() == 0) chk("rvalid_unexpected", {31'b0, bus.data_rvalid_o}, 32'd0);
        else begin
          resp_t e;
          e = rq.pop_front();
          chk("rvalid_cycle", cyc, e.cyc + 1);
          chk("rdata", bus.data_rdata_o, e.data);
        end
      end else if (rq.size() != 0 && cyc > rq[0].cyc) begin
        chk("rvalid_missing", {31'b0, bus.data_rvalid_o}, 32'd1);
        void'(rq.pop_front());
      end
      if (char_valid && char_ready) begin
        if (cq.size() == 0) chk("char_unexpected", {31'b0, char_valid}, 32'd0);
        else                chk("char", {24'b0, char_o}, {24'b0, cq.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.data_req_i = 1'b0; bus.data_addr_i = '0; bus.data_we_i = 1'b0;
    bus.data_be_i = '0; bus.data_wdata_i = '0;
  endtask

  task automatic bus_drive(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd);
    bus.data_req_i = 1'b1; bus.data_addr_i = a; bus.data_we_i = we;
    bus.data_be_i = be; bus.data_wdata_i = wd;
  endtask

  // Called at posedge+1; returns at posedge+1 of the following cycle.
  task automatic xfer(input logic [31:0] a, input logic we, input logic [3:0] be,
                      input logic [31:0] wd, input logic exp_sel, input logic exp_gnt,
                      input logic [31:0] exp_rd, input string nm);
    bus_drive(a, we, be, wd);
    #1;
    chk({nm, "_sel"}, {31'b0, bus.sel_o}, {31'b0, exp_sel});
    chk({nm, "_gnt"}, {31'b0, bus.data_gnt_o}, {31'b0, exp_gnt});
    if (exp_gnt) begin
      rq.push_back('{cyc: cyc, data: exp_rd});
      if (we && a == A_PUTC && be[0]) cq.push_back(wd[7:0]);
    end
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_rvalid"}, {31'b0, bus.data_rvalid_o}, 32'd0);
    chk({nm, "_rdata"}, bus.data_rdata_o, 32'd0);
    chk({nm, "_char_valid"}, {31'b0, char_valid}, 32'd0);
    chk({nm, "_char"}, {24'b0, char_o}, 32'd0);
    chk({nm, "_exit_valid"}, {31'b0, exit_valid}, 32'd0);
    chk({nm, "_exit_code"}, exit_code, 32'd0);
    chk({nm, "_eoc"}, {31'b0, eoc}, 32'd0);
    chk({nm, "_finish"}, {31'b0, finish}, 32'd0);
  endtask

  task automatic do_reset(input string nm);
    #1 rst_n = 1'b0;
    rq.delete(); cq.delete();
    #1;
    chk_reset_vals(nm);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: got no end expected end by 200000");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bus_idle();
    @(posedge clk); #1;
    do_reset("por");
    tick(1);

    // Unmapped address: ignored entirely.
    xfer(A_MISS, 1'b1, 4'hF, 32'h0000_0055, 1'b0, 1'b0, 32'd0, "miss");
    tick(2);
    chk("miss_exit_valid", {31'b0, exit_valid}, 32'd0);
    chk("miss_char_valid", {31'b0, char_valid}, 32'd0);

    // Single character, sink ready.
    char_ready = 1'b1;
    xfer(A_PUTC, 1'b1, 4'b0001, 32'h0000_0041, 1'b1, 1'b1, 32'd0, "putc41");
    chk("putc41_char_valid", {31'b0, char_valid}, 32'd1);
    chk("putc41_char", {24'b0, char_o}, 32'h41);
    tick(1);
    chk("putc41_popped", {31'b0, char_valid}, 32'd0);
    xfer(A_PUTC, 1'b1, 4'b0010, 32'h0000_0042, 1'b1, 1'b1, 32'd0, "putc_be0");
    chk("putc_be0_nopush", {31'b0, char_valid}, 32'd0);

    // Fill FIFO with sink stalled, then overflow attempt.
    char_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      xfer(A_PUTC, 1'b1, 4'b0001, 32'h61 + i, 1'b1, 1'b1, 32'd0, "fill");
    bus_drive(A_PUTC, 1'b1, 4'b0001, 32'h71);
    #1;
    chk("full_sel", {31'b0, bus.sel_o}, 32'd1);
    chk("full_gnt", {31'b0, bus.data_gnt_o}, 32'd0);
    tick(1);
    chk("full_gnt_held", {31'b0, bus.data_gnt_o}, 32'd0);
    bus_idle();
    xfer(A_PUTC, 1'b0, 4'hF, 32'd0, 1'b1, 1'b1, 32'd16, "ld_occ_full");
    xfer(A_EXIT, 1'b0, 4'hF, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, "ld_exit_none");
    bus_drive(A_PUTC, 1'b1, 4'b0001, 32'h71);
    char_ready = 1'b1;
    #1;
    chk("unstall_gnt_pop_cycle", {31'b0, bus.data_gnt_o}, 32'd0);
    tick(1);
    chk("unstall_gnt_next", {31'b0, bus.data_gnt_o}, 32'd1);
    rq.push_back('{cyc: cyc, data: 32'd0});
    cq.push_back(8'h71);
    tick(1);
    bus_idle();
    tick(20);
    chk("drained_char_valid", {31'b0, char_valid}, 32'd0);
    xfer(A_PUTC, 1'b0, 4'hF, 32'd0, 1'b1, 1'b1, 32'd0, "ld_occ_empty");

    // Exit code: first store wins regardless of byte enables.
    xfer(A_EXIT, 1'b1, 4'b0000, 32'h0, 1'b1, 1'b1, 32'd0, "exit0");
    chk("exit0_valid", {31'b0, exit_valid}, 32'd1);
    chk("exit0_code", exit_code, 32'd0);
    xfer(A_EXIT, 1'b1, 4'hF, 32'h5, 1'b1, 1'b1, 32'd0, "exit5");
    chk("exit5_ignored", exit_code, 32'd0);
    xfer(A_EXIT, 1'b0, 4'hF, 32'd0, 1'b1, 1'b1, 32'd0, "ld_exit0");
    tick(3);
    chk("awake_no_eoc", {31'b0, eoc}, 32'd0);

    // EOC waits for an empty FIFO, then drains 10 cycles.
    do_reset("rst2");
    char_ready = 1'b0;
    xfer(A_PUTC, 1'b1, 4'b0001, 32'h78, 1'b1, 1'b1, 32'd0, "px");
    xfer(A_PUTC, 1'b1, 4'b0001, 32'h79, 1'b1, 1'b1, 32'd0, "py");
    core_sleeping = 1'b1;
    xfer(A_EXIT, 1'b1, 4'hF, 32'h3, 1'b1, 1'b1, 32'd0, "exit3");
    chk("exit3_code", exit_code, 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("fifo_busy_no_eoc", {31'b0, eoc}, 32'd0);
    end
    char_ready = 1'b1;
    chk("eoc_p0", {31'b0, eoc}, 32'd0);
    tick(1); chk("eoc_p1", {31'b0, eoc}, 32'd0);
    tick(1); chk("eoc_p2", {31'b0, eoc}, 32'd0);
    tick(1); chk("eoc_p3", {31'b0, eoc}, 32'd1);
    chk("finish_at_eoc", {31'b0, finish}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      tick(1);
      chk("finish_early", {31'b0, finish}, 32'd0);
    end
    tick(1);
    chk("finish_rise", {31'b0, finish}, 32'd1);
    chk("eoc_hold", {31'b0, eoc}, 32'd1);
    xfer(A_PUTC, 1'b1, 4'b0001, 32'h7A, 1'b1, 1'b1, 32'd0, "putc_done");
    tick(2);

    // Reset while draining with characters buffered.
    do_reset("rst3");
    char_ready = 1'b1;
    xfer(A_EXIT, 1'b1, 4'hF, 32'h7, 1'b1, 1'b1, 32'd0, "exit7");
    tick(2);
    chk("exit7_eoc", {31'b0, eoc}, 32'd1);
    char_ready = 1'b0;
    xfer(A_PUTC, 1'b1, 4'b0001, 32'h70, 1'b1, 1'b1, 32'd0, "pp");
    xfer(A_PUTC, 1'b1, 4'b0001, 32'h71, 1'b1, 1'b1, 32'd0, "pq");
    chk("drain_fifo_nonempty", {31'b0, char_valid}, 32'd1);
    xfer(A_EXIT, 1'b0, 4'hF, 32'd0, 1'b1, 1'b1, 32'd7, "ld_exit7");
    chk("drain_not_finished", {31'b0, finish}, 32'd0);
    do_reset("rst_drain");
    xfer(A_EXIT, 1'b1, 4'hF, 32'h9, 1'b1, 1'b1, 32'd0, "exit9");
    chk("exit9_valid", {31'b0, exit_valid}, 32'd1);
    chk("exit9_code", exit_code, 32'd9);
    chk("exit9_eoc", {31'b0, eoc}, 32'd0);
    tick(3);

    chk("resp_queue_drained", rq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
